csc_sequencer: RTL

CSC_SEQUENCER -- requirements
Module: csc_sequencer

---
 rtl/csc_pkg.sv | 34 +++
 rtl/csc_sequencer_if.sv | 27 ++
 rtl/csc_mac.sv | 79 +++++++
 rtl/csc_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/csc_pkg.sv
// Shared constants and FSM state type for the YUV->RGB colour-space sequencer.
// Coefficients are the 16.16 fixed-point BT.601 factors used by csc_mac.
package csc_pkg;

    localparam int DATA_W = 8;
    localparam int COEF_W = 32;
    localparam int ACC_W  = 32;

    localparam logic signed [COEF_W-1:0] C_Y  = 32'sd76284;
    localparam logic signed [COEF_W-1:0] C_RV = 32'sd104595;
    localparam logic signed [COEF_W-1:0] C_GV = 32'sd53281;
    localparam logic signed [COEF_W-1:0] C_BU = 32'sd132251;
    localparam logic signed [COEF_W-1:0] C_GU = 32'sd25624;

    localparam logic [DATA_W-1:0] OFS_Y = 8'd16;
    localparam logic [DATA_W-1:0] OFS_C = 8'd128;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        P0,
        P1,
        P2,
        DRAIN,
        DONE
    } state_t;

    // Unsigned sample minus its offset, widened to the signed accumulator width.
    function automatic logic signed [ACC_W-1:0] centre(input logic [DATA_W-1:0] s,
                                                       input logic [DATA_W-1:0] ofs);
        return $signed({{(ACC_W-DATA_W){1'b0}}, s}) - $signed({{(ACC_W-DATA_W){1'b0}}, ofs});
    endfunction

endpackage

// File: rtl/csc_sequencer_if.sv
// Pixel-in / RGB-out stream bundle of csc_sequencer, both sides valid/ready.
// The slave modport is the sequencer's view; master is the environment's.
interface csc_sequencer_if;
    import csc_pkg::*;

    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] Y_in;
    logic [DATA_W-1:0] U_in;
    logic [DATA_W-1:0] V_in;
    logic              rgb_valid;
    logic              rgb_ready;
    logic [DATA_W-1:0] R_out;
    logic [DATA_W-1:0] G_out;
    logic [DATA_W-1:0] B_out;

    modport master (
        output pix_valid, Y_in, U_in, V_in, rgb_ready,
        input  pix_ready, rgb_valid, R_out, G_out, B_out
    );

    modport slave (
        input  pix_valid, Y_in, U_in, V_in, rgb_ready,
        output pix_ready, rgb_valid, R_out, G_out, B_out
    );

endinterface

// File: rtl/csc_mac.sv
// Two shared signed multipliers plus R/G/B accumulators, phase driven by the sequencer FSM.
// In P2 the outputs are the combinational final sums; accumulators stay frozen there.
module csc_mac
    import csc_pkg::*;
(
    input  logic                     CLOCK_50_I,
    input  logic                     resetn,
    input  state_t                   i_phase,
    input  logic        [DATA_W-1:0] i_y,
    input  logic        [DATA_W-1:0] i_u,
    input  logic        [DATA_W-1:0] i_v,
    output logic signed [ACC_W-1:0]  o_r,
    output logic signed [ACC_W-1:0]  o_g,
    output logic signed [ACC_W-1:0]  o_b
);

    logic signed [ACC_W-1:0] w_op;
    logic signed [ACC_W-1:0] w_coef_a;
    logic signed [ACC_W-1:0] w_coef_b;
    logic signed [ACC_W-1:0] w_prod_a;
    logic signed [ACC_W-1:0] w_prod_b;
    logic signed [ACC_W-1:0] r_acc_r;
    logic signed [ACC_W-1:0] r_acc_g;
    logic signed [ACC_W-1:0] r_acc_b;

    // Multiplier A feeds R/B terms, multiplier B feeds G terms.
    always_comb begin
        w_op     = '0;
        w_coef_a = '0;
        w_coef_b = '0;
        case (i_phase)
            P0: begin
                w_op     = centre(i_y, OFS_Y);
                w_coef_a = C_Y;
                w_coef_b = C_Y;
            end
            P1: begin
                w_op     = centre(i_v, OFS_C);
                w_coef_a = C_RV;
                w_coef_b = C_GV;
            end
            P2: begin
                w_op     = centre(i_u, OFS_C);
                w_coef_a = C_BU;
                w_coef_b = C_GU;
            end
            default: ;
        endcase
    end

    assign w_prod_a = w_op * w_coef_a;
    assign w_prod_b = w_op * w_coef_b;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_acc_r <= '0;
            r_acc_g <= '0;
            r_acc_b <= '0;
        end else begin
            case (i_phase)
                P0: begin
                    r_acc_r <= w_prod_a;
                    r_acc_g <= w_prod_b;
                    r_acc_b <= w_prod_a;
                end
                P1: begin
                    r_acc_r <= r_acc_r + w_prod_a;
                    r_acc_g <= r_acc_g - w_prod_b;
                end
                default: ;
            endcase
        end
    end

    assign o_r = r_acc_r;
    assign o_g = r_acc_g - w_prod_b;
    assign o_b = r_acc_b + w_prod_a;

endmodule

// File: rtl/csc_sequencer.sv
// Frame-level YUV->RGB sequencer: handshakes pixels through csc_mac, one per 4 cycles.
// Define CSC_CLIP_EN to saturate each channel to 0..255; otherwise raw bits [23:16] are output.
module csc_sequencer
    import csc_pkg::*;
#(
    parameter int FRAME_PIXELS = 76800,
    parameter int CNT_W        = 17
) (
    input  logic           CLOCK_50_I,
    input  logic           resetn,
    input  logic           start,
    csc_sequencer_if.slave bus,
    output logic           busy,
    output logic           done
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W:0]          w_cnt_inc;
    logic                    w_more;
    logic [DATA_W-1:0]       r_y;
    logic [DATA_W-1:0]       r_u;
    logic [DATA_W-1:0]       r_v;
    logic                    r_pix_ready;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_rgb_valid;
    logic [DATA_W-1:0]       r_r;
    logic [DATA_W-1:0]       r_g;
    logic [DATA_W-1:0]       r_b;
    logic                    w_pix_hs;
    logic                    w_load;
    logic signed [ACC_W-1:0] w_mac_r;
    logic signed [ACC_W-1:0] w_mac_g;
    logic signed [ACC_W-1:0] w_mac_b;

    function automatic logic [DATA_W-1:0] chan8(input logic signed [ACC_W-1:0] x);
`ifdef CSC_CLIP_EN
        if (x < 0)
            return '0;
        else if (x >= 32'sh0100_0000)
            return '1;
        else
            return DATA_W'(x >>> 16);
`else
        return DATA_W'(x >>> 16);
`endif
    endfunction

    csc_mac u_mac (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .i_phase    (r_state),
        .i_y        (r_y),
        .i_u        (r_u),
        .i_v        (r_v),
        .o_r        (w_mac_r),
        .o_g        (w_mac_g),
        .o_b        (w_mac_b)
    );

    assign w_pix_hs  = bus.pix_valid && r_pix_ready;
    // P2 may load when the output register is empty or being emptied this same cycle.
    assign w_load    = (r_state == P2) && (!r_rgb_valid || bus.rgb_ready);
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_more    = w_cnt_inc < (CNT_W+1)'(FRAME_PIXELS);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)        w_state_nxt = ACCEPT;
            ACCEPT:  if (w_pix_hs)     w_state_nxt = P0;
            P0:                        w_state_nxt = P1;
            P1:                        w_state_nxt = P2;
            P2:      if (w_load)       w_state_nxt = w_more ? ACCEPT : DRAIN;
            DRAIN:   if (!r_rgb_valid) w_state_nxt = DONE;
            DONE:                      w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_pix_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pix_ready <= (w_state_nxt == ACCEPT);
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (w_state_nxt == DONE);
            if (r_state == IDLE && start)
                r_cnt <= '0;
            else if (w_load)
                r_cnt <= w_cnt_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_y <= '0;
            r_u <= '0;
            r_v <= '0;
        end else if (w_pix_hs) begin
            r_y <= bus.Y_in;
            r_u <= bus.U_in;
            r_v <= bus.V_in;
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_rgb_valid <= 1'b0;
            r_r         <= '0;
            r_g         <= '0;
            r_b         <= '0;
        end else if (w_load) begin
            r_rgb_valid <= 1'b1;
            r_r         <= chan8(w_mac_r);
            r_g         <= chan8(w_mac_g);
            r_b         <= chan8(w_mac_b);
        end else if (bus.rgb_ready) begin
            r_rgb_valid <= 1'b0;
        end
    end

    assign bus.pix_ready = r_pix_ready;
    assign bus.rgb_valid = r_rgb_valid;
    assign bus.R_out     = r_r;
    assign bus.G_out     = r_g;
    assign bus.B_out     = r_b;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
